// File: rtl/counter_cmd_arbiter.sv
// Round-robin command arbiter driving a shared up/down counter, with a shadow copy of its value.
// Define CNT_ARB_SAT_EN to stop a command at the counter bounds instead of wrapping.
module counter_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 4,
    parameter int STEP_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          a_reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_dir,
    input  logic [NUM_REQ*STEP_WIDTH-1:0] req_steps,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            done,
    output logic                          sat,
    output logic                          busy,
    output logic                          cnt_s_reset_n,
    output logic                          cnt_enable,
    output logic                          cnt_inc_en,
    output logic                          cnt_dec_en,
    output logic [COUNT_WIDTH-1:0]        shadow_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d, g_q, g_d;
    logic                   dir_q, dir_d;
    logic [STEP_WIDTH-1:0]  rem_q, rem_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d, done_q, done_d;
    logic                   sat_q, sat_d, busy_q, busy_d, rstn_q, rstn_d;
    logic                   en_q, en_d, inc_q, inc_d, dec_q, dec_d;
    logic [COUNT_WIDTH-1:0] shadow_q, shadow_d, shadow_nx;

    logic                   any_valid, hi_found, sel_dir, blk_grant, blk_run;
    logic [IDX_W-1:0]       pick_lo, pick_hi, pick;
    logic [STEP_WIDTH-1:0]  sel_steps;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (IDX_W'(i) == idx) v[i] = 1'b1;
        return v;
    endfunction

`ifdef CNT_ARB_SAT_EN
    function automatic logic at_bound(input logic [COUNT_WIDTH-1:0] v, input logic up);
        return up ? (v == {COUNT_WIDTH{1'b1}}) : (v == '0);
    endfunction
`endif

    // Round-robin pick: lowest valid index >= rr_q, else lowest valid index overall.
    always_comb begin
        any_valid = 1'b0;
        hi_found  = 1'b0;
        pick_lo   = '0;
        pick_hi   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                pick_lo   = IDX_W'(i);
                if (IDX_W'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    pick_hi  = IDX_W'(i);
                end
            end
        end
        pick      = hi_found ? pick_hi : pick_lo;
        sel_dir   = 1'b0;
        sel_steps = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == g_q) begin
                sel_dir   = req_dir[i];
                sel_steps = req_steps[i*STEP_WIDTH +: STEP_WIDTH];
            end
        end
    end

    // Value the counter will hold after the step currently on the bus lands.
    always_comb begin
        shadow_nx = shadow_q;
        if (inc_q)      shadow_nx = shadow_q + COUNT_WIDTH'(1);
        else if (dec_q) shadow_nx = shadow_q - COUNT_WIDTH'(1);
`ifdef CNT_ARB_SAT_EN
        blk_grant = at_bound(shadow_q, sel_dir);
        blk_run   = at_bound(shadow_nx, dir_q);
`else
        blk_grant = 1'b0;
        blk_run   = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        g_d      = g_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        ready_d  = '0;
        done_d   = '0;
        sat_d    = 1'b0;
        en_d     = 1'b0;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        rstn_d   = 1'b1;
        shadow_d = shadow_nx;
        unique case (state_q)
            IDLE: begin
                if (any_valid && rstn_q) begin
                    state_d = GRANT;
                    g_d     = pick;
                    ready_d = onehot(pick);
                end
            end
            GRANT: begin
                dir_d = sel_dir;
                rem_d = sel_steps;
                if (sel_steps == '0 || blk_grant) begin
                    state_d = DONE;
                    done_d  = onehot(g_q);
                    sat_d   = blk_grant && (sel_steps != '0);
                end else begin
                    state_d = RUN;
                    en_d    = 1'b1;
                    inc_d   = sel_dir;
                    dec_d   = !sel_dir;
                end
            end
            RUN: begin
                rem_d = rem_q - STEP_WIDTH'(1);
                if (rem_q == STEP_WIDTH'(1) || blk_run) begin
                    state_d = DONE;
                    done_d  = onehot(g_q);
                    sat_d   = blk_run && (rem_q != STEP_WIDTH'(1));
                end else begin
                    en_d  = 1'b1;
                    inc_d = dir_q;
                    dec_d = !dir_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                rr_d    = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            ready_q  <= '0;
            done_q   <= '0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            rstn_q   <= 1'b0;
            en_q     <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
            busy_q   <= busy_d;
            rstn_q   <= rstn_d;
            en_q     <= en_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            shadow_q <= shadow_d;
        end
    end

    // Command payload needs no reset: it is only consumed after GRANT has loaded it.
    always_ff @(posedge clk) begin
        g_q   <= g_d;
        dir_q <= dir_d;
        rem_q <= rem_d;
    end

    assign req_ready     = ready_q;
    assign done          = done_q;
    assign sat           = sat_q;
    assign busy          = busy_q;
    assign cnt_s_reset_n = rstn_q;
    assign cnt_enable    = en_q;
    assign cnt_inc_en    = inc_q;
    assign cnt_dec_en    = dec_q;
    assign shadow_cnt    = shadow_q;

endmodule
